char_render_ctrl: RTL and testbench

CHAR_RENDER_CTRL -- requirements
Module: char_render_ctrl

---
 rtl/char_render_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_char_render_ctrl.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/char_render_ctrl.sv
// ---------------------------------------------------------------------------
// char_render_ctrl
//
// Renders a short string of glyphs (up to eight characters) onto a VGA
// framebuffer.  For every pixel of every character cell the controller
// presents a flush position to an external combinational glyph decoder.
// It then turns the decoder answer into a registered pixel write, one
// cycle later.
//
// Parameters
//   CELL_W     glyph cell width in pixels, also the horizontal advance
//   CELL_H     glyph cell height in pixels
//   BG_COLOUR  colour written for unset glyph pixels when opaque is set
//
// Ports
//   clock        single clock, all state changes on its rising edge
//   resetn       asynchronous, active-low reset
//   start        render request, only looked at while idle
//   base_x/y     screen origin of character 0
//   str_len      character count 0..8 (9..15 behave as 8)
//   str_codes    eight 6-bit glyph codes, character i at [6i+5:6i]
//   opaque       when set, unset pixels are written in BG_COLOUR
//   hold         freezes scanning while high
//   glyph_code   code of the character being scanned
//   glyph_x/y    screen origin of that character cell
//   flush_x/y    screen position currently asked of the decoder
//   dec_colour   decoder colour for the flush position
//   dec_enable   decoder says the flush position is a set glyph pixel
//   plot         pixel write strobe to the VGA adapter
//   plot_x/y     pixel write position
//   plot_colour  pixel write colour
//   busy         high while scanning or draining
//   done         single-cycle pulse at the end of a render
// ---------------------------------------------------------------------------
module char_render_ctrl #(
   parameter int         CELL_W    = 10,
   parameter int         CELL_H    = 10,
   parameter logic [5:0] BG_COLOUR = 6'b000000
) (
   input  logic        clock,
   input  logic        resetn,
   input  logic        start,
   input  logic [7:0]  base_x,
   input  logic [7:0]  base_y,
   input  logic [3:0]  str_len,
   input  logic [47:0] str_codes,
   input  logic        opaque,
   input  logic        hold,
   output logic [5:0]  glyph_code,
   output logic [7:0]  glyph_x,
   output logic [7:0]  glyph_y,
   output logic [7:0]  flush_x,
   output logic [7:0]  flush_y,
   input  logic [5:0]  dec_colour,
   input  logic        dec_enable,
   output logic        plot,
   output logic [7:0]  plot_x,
   output logic [7:0]  plot_y,
   output logic [5:0]  plot_colour,
   output logic        busy,
   output logic        done
);

   localparam int COL_W = (CELL_W > 1) ? $clog2(CELL_W) : 1;
   localparam int ROW_W = (CELL_H > 1) ? $clog2(CELL_H) : 1;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SCAN  = 2'd1;
   localparam logic [1:0] DRAIN = 2'd2;

   logic [1:0]       state;
   logic [7:0]       base_x_r;
   logic [7:0]       base_y_r;
   logic [3:0]       len_r;
   logic [47:0]      codes_r;
   logic             opaque_r;
   logic [2:0]       ci;
   logic [COL_W-1:0] col;
   logic [ROW_W-1:0] row;

   logic [3:0]       len_clamped;
   logic             col_last;
   logic             row_last;
   logic             char_last;
   logic             advance;
   logic [7:0]       ci_offset;
   logic             on_screen;
   logic             pixel_wanted;

   // Lengths above eight are saturated rather than wrapped, so a sloppy
   // caller still gets a full string instead of garbage.
   assign len_clamped = (str_len > 4'd8) ? 4'd8 : str_len;

   // Scan-position bookkeeping: the last column of a row, the last row of a
   // cell and the last character of the string.  char_last is only ever
   // consulted in SCAN, where len_r is known to be at least one.
   assign col_last  = (col == COL_W'(CELL_W - 1));
   assign row_last  = (row == ROW_W'(CELL_H - 1));
   assign char_last = ({1'b0, ci} == (len_r - 4'd1));
   assign advance   = (state == SCAN) && !hold;

   // Decoder request.  All additions are deliberately 8-bit so positions
   // wrap modulo 256 just like the screen coordinate bus does.
   assign ci_offset  = 8'(int'(ci) * CELL_W);
   assign glyph_code = codes_r[int'(ci) * 6 +: 6];
   assign glyph_x    = base_x_r + ci_offset;
   assign glyph_y    = base_y_r;
   assign flush_x    = glyph_x + 8'(col);
   assign flush_y    = base_y_r + 8'(row);

   // A pixel is written only for a live scan cycle that lands on the
   // 160x120 visible area and is either a set glyph pixel or opaque fill.
   assign on_screen    = (flush_x < 8'd160) && (flush_y < 8'd120);
   assign pixel_wanted = advance && (dec_enable || opaque_r) && on_screen;

   assign busy = (state == SCAN) || (state == DRAIN);
   assign done = (state == DRAIN);

   // Control FSM and scan counters.  In IDLE a start request snapshots the
   // whole request so the caller may change its inputs during the render.
   // In SCAN the column counter ripples into row and character counters;
   // hold simply skips the update so the scan position stays put.  DRAIN
   // exists so done appears exactly once, after the final pixel has been
   // sampled.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state    <= IDLE;
         base_x_r <= 8'd0;
         base_y_r <= 8'd0;
         len_r    <= 4'd0;
         codes_r  <= 48'd0;
         opaque_r <= 1'b0;
         ci       <= 3'd0;
         col      <= '0;
         row      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  base_x_r <= base_x;
                  base_y_r <= base_y;
                  len_r    <= len_clamped;
                  codes_r  <= str_codes;
                  opaque_r <= opaque;
                  ci       <= 3'd0;
                  col      <= '0;
                  row      <= '0;
                  state    <= (len_clamped == 4'd0) ? DRAIN : SCAN;
               end
            end
            SCAN: begin
               if (!hold) begin
                  if (col_last) begin
                     col <= '0;
                     if (row_last) begin
                        row <= '0;
                        if (char_last) begin
                           ci    <= 3'd0;
                           state <= DRAIN;
                        end else begin
                           ci <= ci + 3'd1;
                        end
                     end else begin
                        row <= row + ROW_W'(1);
                     end
                  end else begin
                     col <= col + COL_W'(1);
                  end
               end
            end
            DRAIN: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Registered pixel write, one cycle behind the sampled flush position.
   // Position and colour only move when a write is issued, so the adapter
   // sees stable values between writes.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         plot        <= 1'b0;
         plot_x      <= 8'd0;
         plot_y      <= 8'd0;
         plot_colour <= 6'd0;
      end else begin
         plot <= pixel_wanted;
         if (pixel_wanted) begin
            plot_x      <= flush_x;
            plot_y      <= flush_y;
            plot_colour <= dec_enable ? dec_colour : BG_COLOUR;
         end
      end
   end

endmodule

// File: tb/tb_char_render_ctrl.sv
// ---------------------------------------------------------------------------
// tb_char_render_ctrl
//
// Directed bench for char_render_ctrl.  A small "H" glyph decoder model
// answers the flush requests; a negedge monitor tallies plots, busy and
// done cycles relative to the start cycle; the main sequence then compares
// those tallies with hand-derived values.
// ---------------------------------------------------------------------------
module tb_char_render_ctrl;

   localparam logic [5:0] H_CODE     = 6'd17;
   localparam logic [5:0] FG         = 6'b111000;
   localparam logic [5:0] OFF_COLOUR = 6'b010101;
   localparam logic [5:0] BG         = 6'b000000;

   logic        clock;
   logic        resetn;
   logic        start;
   logic [7:0]  base_x;
   logic [7:0]  base_y;
   logic [3:0]  str_len;
   logic [47:0] str_codes;
   logic        opaque;
   logic        hold;
   logic [5:0]  glyph_code;
   logic [7:0]  glyph_x;
   logic [7:0]  glyph_y;
   logic [7:0]  flush_x;
   logic [7:0]  flush_y;
   logic [5:0]  dec_colour;
   logic        dec_enable;
   logic        plot;
   logic [7:0]  plot_x;
   logic [7:0]  plot_y;
   logic [5:0]  plot_colour;
   logic        busy;
   logic        done;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int start_cyc = 0;
   int rel;
   int idle_rel;

   logic mon_en = 1'b0;
   logic [7:0] mon_bx = 8'd0;
   logic [7:0] mon_by = 8'd0;
   int plot_cnt, bg_cnt, hi_x_cnt, hold_plot_cnt, bad_cnt;
   int busy_cnt, done_cnt, done_cyc, min_x;

   char_render_ctrl #(
      .CELL_W(10),
      .CELL_H(10),
      .BG_COLOUR(BG)
   ) dut (
      .clock(clock),
      .resetn(resetn),
      .start(start),
      .base_x(base_x),
      .base_y(base_y),
      .str_len(str_len),
      .str_codes(str_codes),
      .opaque(opaque),
      .hold(hold),
      .glyph_code(glyph_code),
      .glyph_x(glyph_x),
      .glyph_y(glyph_y),
      .flush_x(flush_x),
      .flush_y(flush_y),
      .dec_colour(dec_colour),
      .dec_enable(dec_enable),
      .plot(plot),
      .plot_x(plot_x),
      .plot_y(plot_y),
      .plot_colour(plot_colour),
      .busy(busy),
      .done(done)
   );

   // 10-unit clock and a count of rising edges seen so far.
   initial clock = 1'b0;
   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   // "H" glyph: columns 2 and 7 of every row plus columns 3..6 of row 5.
   function automatic logic h_pixel(input logic [7:0] x, input logic [7:0] y);
      return (x < 8'd10) && (y < 8'd10) &&
             ((x == 8'd2) || (x == 8'd7) || ((y == 8'd5) && (x >= 8'd3) && (x <= 8'd6)));
   endfunction

   // Decoder model: only code H has set pixels; unset pixels report a
   // distinctive colour so a colour-select fault becomes visible.
   logic [7:0] lx, ly;
   assign lx         = flush_x - glyph_x;
   assign ly         = flush_y - glyph_y;
   assign dec_enable = (glyph_code == H_CODE) && h_pixel(lx, ly);
   assign dec_colour = dec_enable ? FG : OFF_COLOUR;

   // Monitor: tallies outputs from the cycle after start onwards.  A plot
   // in FG must fall on an H pixel of its cell and vice versa.
   always @(negedge clock) begin
      logic [7:0] xr, yr, px;
      if (mon_en) begin
         rel = cyc - start_cyc;
         if (rel >= 1) begin
            if (busy) busy_cnt++;
            if (done) begin
               done_cnt++;
               done_cyc = rel;
            end
            if (plot) begin
               plot_cnt++;
               xr = plot_x - mon_bx;
               yr = plot_y - mon_by;
               px = xr % 8'd10;
               if (plot_colour == BG) bg_cnt++;
               if (plot_x >= 8'd160) hi_x_cnt++;
               if (int'(plot_x) < min_x) min_x = int'(plot_x);
               if ((rel >= 51) && (rel <= 55)) hold_plot_cnt++;
               if ((plot_colour == FG) != h_pixel(px, yr)) bad_cnt++;
            end
         end
      end
   end

   task automatic check_output(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
      end
   endtask

   task automatic clear_mon();
      plot_cnt      = 0;
      bg_cnt        = 0;
      hi_x_cnt      = 0;
      hold_plot_cnt = 0;
      bad_cnt       = 0;
      busy_cnt      = 0;
      done_cnt      = 0;
      done_cyc      = -1;
      min_x         = 255;
   endtask

   // Raise start for one cycle (that cycle is relative cycle 0); returns at
   // the negedge of relative cycle 1.
   task automatic apply_stimulus(input logic [7:0] bx, input logic [7:0] by,
                                 input logic [3:0] len, input logic [47:0] codes,
                                 input logic op);
      @(negedge clock);
      base_x    = bx;
      base_y    = by;
      str_len   = len;
      str_codes = codes;
      opaque    = op;
      start     = 1'b1;
      mon_bx    = bx;
      mon_by    = by;
      clear_mon();
      start_cyc = cyc;
      mon_en    = 1'b1;
      @(negedge clock);
      start = 1'b0;
   endtask

   task automatic wait_rel(input int n);
      for (int i = 0; (i < 2000) && ((cyc - start_cyc) < n); i++) @(negedge clock);
   endtask

   task automatic wait_idle(input string tag, input int limit);
      for (int i = 0; (i < limit) && busy; i++) @(negedge clock);
      idle_rel = cyc - start_cyc;
      check_output(tag, 64'(busy), 64'd0);
   endtask

   task automatic hold_window();
      wait_rel(50);
      hold = 1'b1;
      repeat (5) @(negedge clock);
      hold = 1'b0;
   endtask

   initial begin
      resetn    = 1'b0;
      start     = 1'b0;
      base_x    = 8'd0;
      base_y    = 8'd0;
      str_len   = 4'd0;
      str_codes = 48'd0;
      opaque    = 1'b0;
      hold      = 1'b0;
      clear_mon();
      repeat (3) @(negedge clock);
      check_output("reset_outputs",
                   64'({plot, plot_x, plot_y, plot_colour, busy, done,
                        glyph_code, glyph_x, glyph_y, flush_x, flush_y}), 64'd0);
      resetn = 1'b1;

      // Single transparent H at the origin.
      apply_stimulus(8'd0, 8'd0, 4'd1, {42'd0, H_CODE}, 1'b0);
      wait_idle("t1_idle", 300);
      check_output("t1_done_cycle", 64'(done_cyc), 64'd101);
      check_output("t1_done_count", 64'(done_cnt), 64'd1);
      check_output("t1_busy_cycles", 64'(busy_cnt), 64'd101);
      check_output("t1_idle_cycle", 64'(idle_rel), 64'd102);
      check_output("t1_plots", 64'(plot_cnt), 64'd24);
      check_output("t1_pixel_shape", 64'(bad_cnt), 64'd0);

      // Same, opaque: every cell pixel written, 76 in background colour.
      apply_stimulus(8'd0, 8'd0, 4'd1, {42'd0, H_CODE}, 1'b1);
      wait_idle("t2_idle", 300);
      check_output("t2_plots", 64'(plot_cnt), 64'd100);
      check_output("t2_bg_plots", 64'(bg_cnt), 64'd76);
      check_output("t2_pixel_shape", 64'(bad_cnt), 64'd0);
      check_output("t2_done_cycle", 64'(done_cyc), 64'd101);

      // H straddling the right screen edge.
      apply_stimulus(8'd155, 8'd0, 4'd1, {42'd0, H_CODE}, 1'b0);
      wait_idle("t3_idle", 300);
      check_output("t3_plots", 64'(plot_cnt), 64'd12);
      check_output("t3_offscreen_x", 64'(hi_x_cnt), 64'd0);
      check_output("t3_pixel_shape", 64'(bad_cnt), 64'd0);

      // Opaque H with a five-cycle hold: no writes from held cycles.
      apply_stimulus(8'd0, 8'd0, 4'd1, {42'd0, H_CODE}, 1'b1);
      hold_window();
      wait_idle("t4_idle", 300);
      check_output("t4_hold_plots", 64'(hold_plot_cnt), 64'd0);
      check_output("t4_plots", 64'(plot_cnt), 64'd100);
      check_output("t4_done_cycle", 64'(done_cyc), 64'd106);

      // Two characters (blank, H) with hold: H lands in the second cell.
      apply_stimulus(8'd0, 8'd0, 4'd2, {36'd0, H_CODE, 6'd0}, 1'b0);
      hold_window();
      wait_idle("t5_idle", 400);
      check_output("t5_hold_plots", 64'(hold_plot_cnt), 64'd0);
      check_output("t5_done_cycle", 64'(done_cyc), 64'd206);
      check_output("t5_plots", 64'(plot_cnt), 64'd24);
      check_output("t5_min_x", 64'(min_x), 64'd12);

      // Empty string: straight to the done pulse.
      apply_stimulus(8'd0, 8'd0, 4'd0, {42'd0, H_CODE}, 1'b0);
      wait_idle("t6_idle", 50);
      check_output("t6_done_cycle", 64'(done_cyc), 64'd1);
      check_output("t6_idle_cycle", 64'(idle_rel), 64'd2);
      check_output("t6_plots", 64'(plot_cnt), 64'd0);

      // Start pulsed mid-render with different parameters is ignored.
      apply_stimulus(8'd0, 8'd0, 4'd1, {42'd0, H_CODE}, 1'b0);
      wait_rel(30);
      base_x    = 8'd50;
      str_len   = 4'd8;
      str_codes = {8{H_CODE}};
      opaque    = 1'b1;
      start     = 1'b1;
      @(negedge clock);
      start = 1'b0;
      wait_idle("t7_idle", 300);
      check_output("t7_done_cycle", 64'(done_cyc), 64'd101);
      check_output("t7_done_count", 64'(done_cnt), 64'd1);
      check_output("t7_plots", 64'(plot_cnt), 64'd24);
      check_output("t7_pixel_shape", 64'(bad_cnt), 64'd0);

      // Oversized length saturates at eight characters.
      apply_stimulus(8'd0, 8'd0, 4'd12, {8{H_CODE}}, 1'b0);
      wait_idle("t8_idle", 900);
      check_output("t8_done_cycle", 64'(done_cyc), 64'd801);
      check_output("t8_plots", 64'(plot_cnt), 64'd192);
      check_output("t8_pixel_shape", 64'(bad_cnt), 64'd0);

      // Reset in the middle of a render: outputs clear at once, no resume.
      apply_stimulus(8'd20, 8'd30, 4'd1, {42'd0, H_CODE}, 1'b1);
      wait_rel(40);
      resetn = 1'b0;
      #1;
      check_output("t9_reset_outputs",
                   64'({plot, plot_x, plot_y, plot_colour, busy, done,
                        glyph_code, glyph_x, glyph_y, flush_x, flush_y}), 64'd0);
      repeat (3) @(negedge clock);
      resetn = 1'b1;
      clear_mon();
      start_cyc = cyc;
      repeat (120) @(negedge clock);
      check_output("t9_busy_after", 64'(busy), 64'd0);
      check_output("t9_done_after", 64'(done_cnt), 64'd0);
      check_output("t9_plots_after", 64'(plot_cnt), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
